// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS control path: the main FSM state
// encoding, the supported primary opcodes and the ALUOp codes that the ALU
// control unit decodes.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    R_EXEC    = 4'd2,
    I_EXEC    = 4'd3,
    WB_R      = 4'd4,
    WB_I      = 4'd5,
    MEM_ADDR  = 4'd6,
    MEM_READ  = 4'd7,
    MEM_WB    = 4'd8,
    MEM_WRITE = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11,
    ILLEGAL   = 4'd12
  } state_t;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  // ALUOp codes consumed by the ALU control unit
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;
  localparam logic [2:0] ALUOP_ADD   = 3'b100;
  localparam logic [2:0] ALUOP_OR    = 3'b101;
  localparam logic [2:0] ALUOP_LUI   = 3'b110;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;

  // States that wait on the memory handshake and are covered by the timeout.
  function automatic logic is_mem_state(state_t s);
    return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// -----------------------------------------------------------------------------
// mc_wait_timer
// Counts the cycles a memory state has spent waiting for mem_ready and flags
// the cycle in which the wait reaches MEM_TIMEOUT cycles without a response.
//   clk        system clock, rising edge
//   reset      synchronous, active-low reset
//   i_clear    restart the count next cycle (state entry / abort)
//   i_wait     a memory state is waiting this cycle (mem_ready low)
//   o_timeout  last allowed wait cycle has passed without mem_ready
// MEM_TIMEOUT must lie in 1..255 so the terminal count fits in 8 bits.
// -----------------------------------------------------------------------------
module mc_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_wait,
  output logic o_timeout
);

  localparam logic [7:0] TERM_CNT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] r_wait_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!reset)        r_wait_cnt <= '0;
    else if (i_clear)  r_wait_cnt <= '0;
    else if (i_wait)   r_wait_cnt <= r_wait_cnt + 8'd1;
  end

  // Qualified by i_wait so a mem_ready arriving on the last cycle still wins.
  assign o_timeout = i_wait && (r_wait_cnt == TERM_CNT);

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the multi-cycle MIPS datapath. Sequences fetch, decode,
// execute, memory and write-back, and drives every datapath enable and mux
// select plus the 3-bit ALUOp. Memory states use a ready handshake guarded by
// a timeout (mc_wait_timer).
//   clk, reset            clock / synchronous active-low reset
//   opcode, zero          IR opcode (valid in DECODE), ALU zero (valid in BRANCH)
//   mem_ready             memory completed this cycle
//   pc_write .. alu_op    datapath enables and selects
//   instr_done            pulse when an instruction retires
//   illegal_op            pulse for an unsupported opcode
//   mem_error             pulse when a memory wait times out
// -----------------------------------------------------------------------------
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ior_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_error
);

  state_t     r_state;
  state_t     w_next_state;
  logic [5:0] r_op_q;
  logic       w_wait;
  logic       w_timeout;
  logic       w_timer_clear;

  assign w_wait        = is_mem_state(r_state) && !mem_ready;
  // Restart the count on every state change, after an abort (FETCH re-enters
  // itself) and whenever the FSM is outside the memory states.
  assign w_timer_clear = (w_next_state != r_state) || w_timeout ||
                         !is_mem_state(r_state);

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_timer_clear),
    .i_wait    (w_wait),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= FETCH;
      r_op_q  <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == DECODE) r_op_q <= opcode;
    end
  end

  // NOTE: every output and the next state get a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    w_next_state = r_state;
    pc_write     = 1'b0;
    ior_d        = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    mem_to_reg   = 1'b0;
    reg_dst      = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    pc_source    = 2'b00;
    alu_op       = 3'b000;
    instr_done   = 1'b0;
    illegal_op   = 1'b0;
    mem_error    = 1'b0;

    // While reset is low every enable stays quiet, so an interrupted
    // instruction never writes the register file or memory.
    if (!reset) begin
      w_next_state = FETCH;
    end else if (w_timeout) begin
      mem_error    = 1'b1;
      w_next_state = FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = ALUOP_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          if (mem_ready) w_next_state = DECODE;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          alu_op    = ALUOP_ADD;
          case (opcode)
            OP_R:                  w_next_state = R_EXEC;
            OP_ADDI, OP_ORI,
            OP_LUI:                w_next_state = I_EXEC;
            OP_LW, OP_SW:          w_next_state = MEM_ADDR;
            OP_BEQ, OP_BNE:        w_next_state = BRANCH;
            OP_J:                  w_next_state = JUMP;
            default:               w_next_state = ILLEGAL;
          endcase
        end
        R_EXEC: begin
          alu_src_a    = 1'b1;
          alu_op       = ALUOP_RTYPE;
          w_next_state = WB_R;
        end
        I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          case (r_op_q)
            OP_ORI:  alu_op = ALUOP_OR;
            OP_LUI:  alu_op = ALUOP_LUI;
            default: alu_op = ALUOP_ADD;
          endcase
          w_next_state = WB_I;
        end
        WB_R: begin
          reg_write    = 1'b1;
          reg_dst      = 1'b1;
          instr_done   = 1'b1;
          w_next_state = FETCH;
        end
        WB_I: begin
          reg_write    = 1'b1;
          instr_done   = 1'b1;
          w_next_state = FETCH;
        end
        MEM_ADDR: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b10;
          alu_op       = ALUOP_ADD;
          w_next_state = (r_op_q == OP_SW) ? MEM_WRITE : MEM_READ;
        end
        MEM_READ: begin
          mem_read = 1'b1;
          ior_d    = 1'b1;
          if (mem_ready) w_next_state = MEM_WB;
        end
        MEM_WB: begin
          reg_write    = 1'b1;
          mem_to_reg   = 1'b1;
          instr_done   = 1'b1;
          w_next_state = FETCH;
        end
        MEM_WRITE: begin
          mem_write  = 1'b1;
          ior_d      = 1'b1;
          instr_done = mem_ready;
          if (mem_ready) w_next_state = FETCH;
        end
        BRANCH: begin
          alu_src_a    = 1'b1;
          alu_op       = ALUOP_SUB;
          pc_source    = 2'b01;
          pc_write     = ((r_op_q == OP_BEQ) && zero) ||
                         ((r_op_q == OP_BNE) && !zero);
          instr_done   = 1'b1;
          w_next_state = FETCH;
        end
        JUMP: begin
          pc_source    = 2'b10;
          pc_write     = 1'b1;
          instr_done   = 1'b1;
          w_next_state = FETCH;
        end
        ILLEGAL: begin
          // PC already advanced in FETCH, so the bad word is simply skipped.
          illegal_op   = 1'b1;
          w_next_state = FETCH;
        end
        default: w_next_state = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Self-checking bench for multicycle_control. Each instruction is expanded
// into a per-cycle list of {inputs, expected outputs} from the instruction's
// class, memory wait lengths and branch condition; the list is then replayed
// cycle by cycle against the DUT.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int TO = 15;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_ORI  = 6'b001101;
  localparam logic [5:0] T_LUI  = 6'b001111;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_BNE  = 6'b000101;
  localparam logic [5:0] T_J    = 6'b000010;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ior_d, mem_read, mem_write, ir_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, instr_done, illegal_op, mem_error;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;

  typedef struct packed {
    logic       pc_write;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_error;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic       rdy;
    outs_t      exp;
    string      tag;
  } step_t;

  step_t q[$];
  int    checks   = 0;
  int    failures = 0;

  multicycle_control #(.MEM_TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ior_d      (ior_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_source  (pc_source),
    .alu_op     (alu_op),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .mem_error  (mem_error)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] rand_op();
    return 6'($urandom);
  endfunction

  // One cycle with reset released, the given mem_ready/opcode, random zero
  // and every output expected low unless the caller sets it.
  function automatic step_t mk(string tag, logic rdy, logic [5:0] op);
    step_t s;
    s.rst = 1'b1;
    s.op  = op;
    s.z   = 1'($urandom);
    s.rdy = rdy;
    s.exp = '0;
    s.tag = tag;
    return s;
  endfunction

  task automatic reset_steps(int n);
    step_t s;
    for (int i = 0; i < n; i++) begin
      s = mk("RESET", 1'($urandom), rand_op());
      s.rst = 1'b0;
      q.push_back(s);
    end
  endtask

  // Memory handshake phase: `waits` cycles with mem_ready low, then one
  // cycle with it high; a wait of TO or more cycles aborts on cycle TO.
  task automatic mem_phase(string tag, outs_t busy, outs_t done, int waits,
                           output bit aborted);
    step_t s;
    int    n_busy;
    aborted = 1'b0;
    n_busy  = (waits >= TO) ? TO - 1 : waits;
    for (int i = 0; i < n_busy; i++) begin
      s = mk({tag, "_wait"}, 1'b0, rand_op());
      s.exp = busy;
      q.push_back(s);
    end
    if (waits >= TO) begin
      s = mk({tag, "_timeout"}, 1'b0, rand_op());
      s.exp.mem_error = 1'b1;
      q.push_back(s);
      aborted = 1'b1;
    end else begin
      s = mk({tag, "_done"}, 1'b1, rand_op());
      s.exp = done;
      q.push_back(s);
    end
  endtask

  // Expected cycle trace of one instruction.
  task automatic gen_instr(logic [5:0] op, int fwait, int mwait, logic bz);
    step_t s;
    outs_t b, d;
    bit    ab;
    b = '0;
    b.mem_read  = 1'b1;
    b.alu_src_b = 2'b01;
    b.alu_op    = 3'b100;
    d = b;
    d.ir_write  = 1'b1;
    d.pc_write  = 1'b1;
    mem_phase("FETCH", b, d, fwait, ab);
    if (ab) return;

    s = mk("DECODE", 1'($urandom), op);
    s.exp.alu_src_b = 2'b11;
    s.exp.alu_op    = 3'b100;
    q.push_back(s);

    case (op)
      T_R, T_ADDI, T_ORI, T_LUI: begin
        s = mk("EXEC", 1'($urandom), rand_op());
        s.exp.alu_src_a = 1'b1;
        s.exp.alu_src_b = (op == T_R) ? 2'b00 : 2'b10;
        s.exp.alu_op    = (op == T_R)   ? 3'b111 :
                          (op == T_ORI) ? 3'b101 :
                          (op == T_LUI) ? 3'b110 : 3'b100;
        q.push_back(s);
        s = mk("WB", 1'($urandom), rand_op());
        s.exp.reg_write  = 1'b1;
        s.exp.reg_dst    = (op == T_R);
        s.exp.instr_done = 1'b1;
        q.push_back(s);
      end
      T_LW, T_SW: begin
        s = mk("MEM_ADDR", 1'($urandom), rand_op());
        s.exp.alu_src_a = 1'b1;
        s.exp.alu_src_b = 2'b10;
        s.exp.alu_op    = 3'b100;
        q.push_back(s);
        b = '0;
        b.ior_d     = 1'b1;
        b.mem_read  = (op == T_LW);
        b.mem_write = (op == T_SW);
        d = b;
        d.instr_done = (op == T_SW);
        mem_phase((op == T_LW) ? "MEM_READ" : "MEM_WRITE", b, d, mwait, ab);
        if (!ab && op == T_LW) begin
          s = mk("MEM_WB", 1'($urandom), rand_op());
          s.exp.reg_write  = 1'b1;
          s.exp.mem_to_reg = 1'b1;
          s.exp.instr_done = 1'b1;
          q.push_back(s);
        end
      end
      T_BEQ, T_BNE: begin
        s = mk((op == T_BEQ) ? "BEQ" : "BNE", 1'($urandom), rand_op());
        s.z = bz;
        s.exp.alu_src_a  = 1'b1;
        s.exp.alu_op     = 3'b001;
        s.exp.pc_source  = 2'b01;
        s.exp.pc_write   = (op == T_BEQ) ? bz : !bz;
        s.exp.instr_done = 1'b1;
        q.push_back(s);
      end
      T_J: begin
        s = mk("JUMP", 1'($urandom), rand_op());
        s.exp.pc_source  = 2'b10;
        s.exp.pc_write   = 1'b1;
        s.exp.instr_done = 1'b1;
        q.push_back(s);
      end
      default: begin
        s = mk("ILLEGAL", 1'($urandom), rand_op());
        s.exp.illegal_op = 1'b1;
        q.push_back(s);
      end
    endcase
  endtask

  task automatic run_queue();
    step_t       s;
    outs_t       got;
    logic [18:0] got_v, exp_v;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      reset     = s.rst;
      opcode    = s.op;
      zero      = s.z;
      mem_ready = s.rdy;
      #1;
      got = {pc_write, ior_d, mem_read, mem_write, ir_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op,
             instr_done, illegal_op, mem_error};
      got_v = got;
      exp_v = s.exp;
      checks++;
      assert (got === s.exp) else begin
        failures++;
        $error("FAIL %s t=%0t observed=%05h expected=%05h", s.tag, $time,
               got_v, exp_v);
      end
    end
  endtask

  initial begin
    logic [5:0] legal [9];
    step_t      s;
    int         k;
    legal = '{T_R, T_ADDI, T_ORI, T_LUI, T_LW, T_SW, T_BEQ, T_BNE, T_J};

    reset_steps(2);

    // Directed scenarios
    gen_instr(T_R,    0, 0, 1'b0);
    gen_instr(T_LW,   0, 3, 1'b0);
    gen_instr(T_BEQ,  0, 0, 1'b1);
    gen_instr(T_BNE,  0, 0, 1'b1);
    gen_instr(T_BEQ,  0, 0, 1'b0);
    gen_instr(T_BNE,  0, 0, 1'b0);
    gen_instr(T_ORI,  0, 0, 1'b0);
    gen_instr(T_LUI,  0, 0, 1'b0);
    gen_instr(6'b111111, 0, 0, 1'b0);
    gen_instr(T_R,    TO, 0, 1'b0);
    gen_instr(T_ADDI, TO - 1, 0, 1'b0);
    gen_instr(T_LW,   0, TO, 1'b0);
    gen_instr(T_SW,   0, TO, 1'b0);
    gen_instr(T_SW,   1, TO - 1, 1'b0);
    gen_instr(T_LW,   2, TO - 1, 1'b0);
    gen_instr(T_J,    0, 0, 1'b0);

    // Reset while an LW waits in MEM_READ: nothing may be written.
    gen_instr(T_ADDI, 0, 0, 1'b0);
    s = mk("FETCH_done", 1'b1, rand_op());
    s.exp.mem_read = 1'b1; s.exp.alu_src_b = 2'b01; s.exp.alu_op = 3'b100;
    s.exp.ir_write = 1'b1; s.exp.pc_write = 1'b1;
    q.push_back(s);
    s = mk("DECODE", 1'b1, T_LW);
    s.exp.alu_src_b = 2'b11; s.exp.alu_op = 3'b100;
    q.push_back(s);
    s = mk("MEM_ADDR", 1'b1, rand_op());
    s.exp.alu_src_a = 1'b1; s.exp.alu_src_b = 2'b10; s.exp.alu_op = 3'b100;
    q.push_back(s);
    s = mk("MEM_READ_wait", 1'b0, rand_op());
    s.exp.mem_read = 1'b1; s.exp.ior_d = 1'b1;
    q.push_back(s);
    reset_steps(3);
    gen_instr(T_R, 0, 0, 1'b0);

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      logic [5:0] op;
      int         fw, mw;
      k  = $urandom_range(0, 9);
      op = (k == 9) ? rand_op() : legal[k];
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TO)
                                       : $urandom_range(0, 2);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TO)
                                       : $urandom_range(0, 2);
      gen_instr(op, fw, mw, 1'($urandom));
      if ($urandom_range(0, 29) == 0) reset_steps(1);
    end

    run_queue();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multi-cycle MIPS datapath. It sequences the fetch/decode/execute/memory/write-back steps and drives every datapath enable and mux select. It also produces the 3-bit ALUOp consumed by the ALU control unit. Memory accesses use a ready handshake with a timeout, so wait-state memories are supported.

Parameters:
MEM_TIMEOUT, 15, maximum cycles a memory state waits for mem_ready before aborting (must be 1..255).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
opcode  input  6  instruction[31:26], valid from the IR in DECODE
zero  input  1  ALU zero flag, valid in BRANCH
mem_ready  input  1  memory done this cycle (read data valid / write accepted)
pc_write  output  1  PC load enable, with the branch condition already folded in
ior_d  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  instruction register load
mem_to_reg  output  1  write-back source: 0 = ALUOut, 1 = MDR
reg_dst  output  1  destination register: 0 = rt, 1 = rd
reg_write  output  1  register file write enable
alu_src_a  output  1  ALU A input: 0 = PC, 1 = rs
alu_src_b  output  2  ALU B input: 00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm shifted left 2
pc_source  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
alu_op  output  3  ALUOp: 111 = R-type, 100 = add, 101 = or, 110 = lui, 001 = sub (branch)
instr_done  output  1  one-cycle pulse when an instruction retires
illegal_op  output  1  one-cycle pulse for an unsupported opcode
mem_error  output  1  one-cycle pulse on memory timeout

Behaviour:
- Single clock clk. Reset is synchronous and active-low: if reset==0 at a rising edge, the block enters FETCH, clears op_q and wait_cnt, and drives all pulses low.
- Reset mid-instruction abandons the instruction with no register-file or memory write.
- Outputs are Moore decodes of the state, except the mem_ready-qualified enables noted below.
- When a state does not drive a signal, that signal is 0.
- Supported opcodes: R 000000, ADDI 001000, ORI 001101, LUI 001111, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010.
- FETCH:
  - mem_read=1, ior_d=0, alu_src_a=0, alu_src_b=01, alu_op=100, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay.
- DECODE:
  - Latch opcode into op_q.
  - alu_src_a=0, alu_src_b=11, alu_op=100 (branch target into ALUOut).
  - Next state: R->R_EXEC; ADDI/ORI/LUI->I_EXEC; LW/SW->MEM_ADDR; BEQ/BNE->BRANCH; J->JUMP; else ILLEGAL.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=111 -> WB_R.
- I_EXEC: alu_src_a=1, alu_src_b=10; alu_op=100 (ADDI), 101 (ORI) or 110 (LUI) from op_q -> WB_I.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=100 -> MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ: mem_read=1, ior_d=1; mem_ready=1 -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1 -> FETCH.
- MEM_WRITE: mem_write=1, ior_d=1; mem_ready=1 -> FETCH with instr_done=1 in the same cycle.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01.
  - pc_write=(op_q==BEQ & zero) | (op_q==BNE & ~zero).
  - instr_done=1 -> FETCH.
- JUMP: pc_source=10, pc_write=1, instr_done=1 -> FETCH.
- ILLEGAL: illegal_op=1, no writes -> FETCH. PC has already advanced by 4, so the bad instruction is skipped.
- Memory wait timer (FETCH, MEM_READ, MEM_WRITE):
  - wait_cnt clears on state entry and increments each cycle mem_ready=0.
  - If wait_cnt==MEM_TIMEOUT-1 and mem_ready=0: mem_error=1 that cycle, no enables asserted, next state FETCH.
  - mem_ready in the same cycle as the timeout wins: a normal transition, no error.
- Latency with zero-wait memory: R/I 4 cycles, LW 5, SW 4, BEQ/BNE/J 3.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum (FETCH, DECODE, R_EXEC, I_EXEC, WB_R, WB_I, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, ILLEGAL), 4-bit encoding;
  - opcode localparams;
  - ALUOp constants (111/100/101/110/001), shared with the ALU control unit.
- One sub-module, mc_wait_timer: counter plus terminal-count compare for the memory timeout.

Test Plan:
- Reset held low 3 cycles during MEM_READ, then released, mem_ready=1 -> FETCH on the next cycle, all enables 0 during reset, no reg_write.
- ADD (opcode 000000), mem_ready=1 -> states FETCH, DECODE, R_EXEC, WB_R; alu_op=111 in R_EXEC; reg_write=1 with reg_dst=1 in cycle 4; instr_done=1 once.
- LW with mem_ready delayed 3 cycles in MEM_READ -> stays in MEM_READ 3 cycles with ior_d=1, then MEM_WB with mem_to_reg=1; total 8 cycles.
- BEQ with zero=1 gives pc_write=1 and pc_source=01; BNE with zero=1 gives pc_write=0; in both, alu_op=001 in BRANCH.
- ORI then LUI -> alu_op=101 then 110 in I_EXEC, each followed by WB_I with reg_dst=0.
- Opcode 111111 -> illegal_op pulse, no writes, back to FETCH. FETCH with mem_ready stuck 0 and MEM_TIMEOUT=15 -> mem_error pulse on cycle 15, then a fresh FETCH.
